// File: rtl/i2c_master_seq.sv
// i2c_master_seq: single-master I2C register write/read sequencer.
// Takes one command over valid/ready, runs the whole bus transaction on the
// open-drain SCL/SDA pads, checks target ACKs and returns a 1-cycle response.
module i2c_master_seq #(
  parameter int unsigned CLK_DIV = 62
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_addr,
  input  logic [7:0] cmd_reg_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic [7:0] rsp_rdata,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StTx, StRstart, StRx, StStop, StDone
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_q;       // quarter-bit phase within the current step
  logic [3:0]      r_bit;     // 0..7 data bits, 8 = ACK/NACK slot
  logic [1:0]      r_byte;    // 0 dev+W, 1 reg, 2 wdata, 3 dev+R
  logic [7:0]      r_shift;
  logic [7:0]      r_rx;
  logic            r_rw;
  logic [6:0]      r_dev;
  logic [7:0]      r_reg;
  logic [7:0]      r_wdata;
  logic            r_sample;
  logic            r_err;
  logic            r_ready;
  logic            r_rsp_valid;
  logic            r_rsp_nack;
  logic [7:0]      r_rsp_rdata;
  logic            r_scl_oe;
  logic            r_sda_oe;

  logic w_busy, w_tick, w_step_end, w_bit_scl, w_scl, w_sda;

  assign w_busy     = (r_state != StIdle) && (r_state != StDone);
  assign w_tick     = w_busy && (r_cnt == CntMax);
  assign w_step_end = w_tick && (r_q == 2'd3);
  // SCL is held low in q0 and q3 of a data step, released in q1/q2.
  assign w_bit_scl  = (r_q == 2'd0) || (r_q == 2'd3);

  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_nack  = r_rsp_nack;
  assign rsp_rdata = r_rsp_rdata;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

  // Pad pull-down pattern for the current state and quarter-bit phase.
  always_comb begin
    w_scl = 1'b0;
    w_sda = 1'b0;
    unique case (r_state)
      StStart: begin
        w_scl = (r_q == 2'd3);
        w_sda = (r_q != 2'd0);
      end
      StTx: begin
        w_scl = w_bit_scl;
        w_sda = (r_bit != 4'd8) ? ~r_shift[7] : 1'b0;
      end
      StRx:     w_scl = w_bit_scl;
      StRstart: begin
        w_scl = w_bit_scl;
        w_sda = r_q[1];
      end
      StStop: begin
        w_scl = (r_q == 2'd0);
        w_sda = (r_q != 2'd3);
      end
      default: begin
        w_scl = 1'b0;
        w_sda = 1'b0;
      end
    endcase
  end

  // Sequencer: tick divider, step/bit/byte progression, ACK check and response.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_q         <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
      r_rx        <= '0;
      r_rw        <= 1'b0;
      r_dev       <= '0;
      r_reg       <= '0;
      r_wdata     <= '0;
      r_sample    <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_nack  <= 1'b0;
      r_rsp_rdata <= '0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
    end else begin
      r_scl_oe    <= w_scl;
      r_sda_oe    <= w_sda;
      r_rsp_valid <= 1'b0;

      if (w_busy) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      else        r_cnt <= '0;

      if (w_tick) r_q <= r_q + 2'd1;

      // Sample SDA on the last cycle of q2, while SCL is high.
      if (w_tick && (r_q == 2'd2)) begin
        r_sample <= sda_in;
        if ((r_state == StRx) && (r_bit != 4'd8)) r_rx <= {r_rx[6:0], sda_in};
      end

      case (r_state)
        StIdle: begin
          if (r_ready && cmd_valid) begin
            r_ready <= 1'b0;
            r_state <= StStart;
            r_rw    <= cmd_rw;
            r_dev   <= cmd_dev_addr;
            r_reg   <= cmd_reg_addr;
            r_wdata <= cmd_wdata;
            r_shift <= {cmd_dev_addr, 1'b0};
            r_byte  <= 2'd0;
            r_bit   <= 4'd0;
            r_q     <= 2'd0;
            r_err   <= 1'b0;
            r_rx    <= '0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        StStart: if (w_step_end) begin
          r_state <= StTx;
          r_bit   <= 4'd0;
        end
        StTx: if (w_step_end) begin
          if (r_bit != 4'd8) begin
            r_bit   <= r_bit + 4'd1;
            r_shift <= {r_shift[6:0], 1'b0};
          end else begin
            r_bit <= 4'd0;
            if (r_sample) begin
              // Target NACK: skip remaining bytes and close the bus.
              r_err   <= 1'b1;
              r_state <= StStop;
            end else begin
              case (r_byte)
                2'd0: begin
                  r_byte  <= 2'd1;
                  r_shift <= r_reg;
                end
                2'd1: begin
                  if (r_rw) begin
                    r_state <= StRstart;
                  end else begin
                    r_byte  <= 2'd2;
                    r_shift <= r_wdata;
                  end
                end
                2'd2:    r_state <= StStop;
                default: r_state <= StRx;
              endcase
            end
          end
        end
        StRstart: if (w_step_end) begin
          r_state <= StTx;
          r_byte  <= 2'd3;
          r_shift <= {r_dev, 1'b1};
          r_bit   <= 4'd0;
        end
        StRx: if (w_step_end) begin
          if (r_bit != 4'd8) begin
            r_bit <= r_bit + 4'd1;
          end else begin
            r_bit   <= 4'd0;
            r_state <= StStop;
          end
        end
        StStop: if (w_step_end) begin
          r_state     <= StDone;
          r_rsp_valid <= 1'b1;
          r_rsp_nack  <= r_err;
          r_rsp_rdata <= (r_rw && !r_err) ? r_rx : 8'h00;
        end
        StDone: begin
          r_state <= StIdle;
          r_ready <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: randomized bench for i2c_master_seq with a bus-level
// I2C target model and a transaction-level reference of expected results.
module tb_i2c_master_seq;

  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h70;
  localparam int MK_START = 'h100;
  localparam int MK_STOP  = 'h200;

  logic       clk_25 = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_nack;
  logic [7:0] rsp_rdata;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;
  bit         s_drive;

  int n_total = 0;
  int n_bad   = 0;

  // Target model state shared with the stimulus.
  logic [7:0] bank     [256];
  logic [7:0] ref_bank [256];
  int         log_q [$];
  int         nack_at = 99;
  bit         mack;
  bit         slv_reset;

  assign sda_in = ~(sda_oe | s_drive);

  always #5 clk_25 = ~clk_25;

  i2c_master_seq #(.CLK_DIV(CLK_DIV)) dut (
    .clk_25       (clk_25),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_nack     (rsp_nack),
    .rsp_rdata    (rsp_rdata),
    .scl_oe       (scl_oe),
    .sda_oe       (sda_oe),
    .sda_in       (sda_in)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus-level I2C target: logs START/STOP and every byte the master sends,
  // ACKs its own address, holds a register bank, serves reads.
  initial begin : target
    bit scl, sda, prev_scl, prev_sda, skip, first, tx_mode, go_tx, addressed, rw;
    int bitc, byte_n;
    logic [7:0] sh, rd_byte, ptr;
    logic [2:0] bi;
    prev_scl = 1; prev_sda = 1; skip = 0; first = 0; tx_mode = 0; go_tx = 0;
    addressed = 0; rw = 0; bitc = 0; byte_n = 0; sh = 0; rd_byte = 0; ptr = 0;
    s_drive = 0;
    forever begin
      @(negedge clk_25);
      if (slv_reset) begin
        s_drive = 0; bitc = 0; tx_mode = 0; go_tx = 0; addressed = 0;
        skip = 0; first = 0; byte_n = 0; slv_reset = 0;
      end
      scl = !scl_oe;
      sda = !(sda_oe || s_drive);
      if (scl && prev_scl && prev_sda && !sda) begin
        log_q.push_back(MK_START);
        bitc = 0; skip = 1; first = 1; tx_mode = 0; go_tx = 0; s_drive = 0;
      end else if (scl && prev_scl && !prev_sda && sda) begin
        log_q.push_back(MK_STOP);
        byte_n = 0; addressed = 0; tx_mode = 0; go_tx = 0; s_drive = 0;
      end else if (scl && !prev_scl) begin
        if (bitc < 8 && !tx_mode) sh = {sh[6:0], sda};
        if (bitc == 8 && tx_mode) mack = sda;
      end else if (!scl && prev_scl) begin
        if (skip) begin
          skip = 0;
        end else begin
          bitc++;
          if (bitc == 8) begin
            s_drive = 0;
            if (!tx_mode) begin
              log_q.push_back(int'(sh));
              if (first) begin
                addressed = (sh[7:1] == SLV_ADDR);
                rw = sh[0];
                s_drive = addressed;
                go_tx = addressed && rw;
              end else begin
                s_drive = addressed && (byte_n != nack_at);
                if (s_drive) begin
                  if (byte_n == 1) ptr = sh;
                  else bank[ptr] = sh;
                end
              end
              first = 0;
              byte_n++;
            end
          end else if (bitc == 9) begin
            bitc = 0;
            s_drive = 0;
            if (tx_mode && mack) begin
              tx_mode = 0;
            end else if (go_tx) begin
              go_tx = 0;
              tx_mode = 1;
              rd_byte = bank[ptr];
            end
          end
          if (tx_mode && bitc < 8) begin
            bi = 3'(7 - bitc);
            s_drive = !rd_byte[bi];
          end
        end
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  // One command end to end: reference expectations, handshake, response and bus log.
  task automatic run_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                         input logic [7:0] wd, input int nk);
    int exp_log [$];
    int ticks, n, w, extra;
    logic exp_nack, exp_mack, v, seen, snack;
    logic [7:0] exp_rdata, srd;
    exp_nack = 0; exp_mack = 0; exp_rdata = 8'h00;
    exp_log.push_back(MK_START);
    exp_log.push_back(int'({dev, 1'b0}));
    if (dev != SLV_ADDR) begin
      exp_nack = 1; ticks = 4 + 36 + 4;
    end else if (nk == 1) begin
      exp_log.push_back(int'(ra)); exp_nack = 1; ticks = 4 + 2 * 36 + 4;
    end else if (!rw) begin
      exp_log.push_back(int'(ra)); exp_log.push_back(int'(wd));
      ticks = 4 + 3 * 36 + 4;
      exp_nack = (nk == 2);
      if (!exp_nack) ref_bank[ra] = wd;
    end else begin
      exp_log.push_back(int'(ra)); exp_log.push_back(MK_START);
      exp_log.push_back(int'({dev, 1'b1}));
      ticks = 4 + 2 * 36 + 4 + 2 * 36 + 4;
      exp_rdata = ref_bank[ra];
      exp_mack = 1;
    end
    exp_log.push_back(MK_STOP);

    @(negedge clk_25);
    nack_at = nk; log_q.delete(); mack = 0;
    cmd_rw = rw; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk_25);
      w++;
    end
    if (!cmd_ready) begin
      check_eq("accept", 32'(cmd_ready), 1);
      cmd_valid = 0;
      return;
    end
    @(posedge clk_25);
    n = 0; seen = 0;
    while (!seen && n < 4000) begin
      @(negedge clk_25);
      if (n == 0) check_eq("ready_low", 32'(cmd_ready), 0);
      v = rsp_valid; snack = rsp_nack; srd = rsp_rdata;
      if (v) begin
        cmd_valid = 0;
      end else begin
        // Busy: keep requesting with scrambled fields; must be ignored.
        cmd_rw = 1'($urandom); cmd_dev_addr = 7'($urandom);
        cmd_reg_addr = 8'($urandom); cmd_wdata = 8'($urandom);
      end
      @(posedge clk_25);
      n++;
      seen = v;
    end
    check_eq("rsp_seen", 32'(seen), 1);
    if (!seen) begin
      cmd_valid = 0;
      return;
    end
    check_eq("latency", n, ticks * CLK_DIV + 1);
    check_eq("rsp_nack", 32'(snack), 32'(exp_nack));
    check_eq("rsp_rdata", 32'(srd), 32'(exp_rdata));
    check_eq("log_len", log_q.size(), exp_log.size());
    foreach (exp_log[i])
      if (i < log_q.size()) check_eq($sformatf("log_item%0d", i), log_q[i], exp_log[i]);
    if (exp_mack) check_eq("master_nack", 32'(mack), 1);
    extra = 0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      @(negedge clk_25);
      if (rsp_valid) extra++;
    end
    check_eq("extra_rsp", extra, 0);
    check_eq("hold_nack", 32'(rsp_nack), 32'(exp_nack));
    check_eq("hold_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check_eq("idle_ready", 32'(cmd_ready), 1);
    check_eq("idle_lines", 32'({scl_oe, sda_oe}), 0);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] v8;
    int w, pulses, k, nk;
    reset = 1; cmd_valid = 0; cmd_rw = 0; cmd_dev_addr = 0; cmd_reg_addr = 0; cmd_wdata = 0;
    slv_reset = 0;
    for (int i = 0; i < 256; i++) begin
      v8 = 8'($urandom);
      bank[i] = v8;
      ref_bank[i] = v8;
    end
    bank[3] = 8'h5A;
    ref_bank[3] = 8'h5A;

    repeat (3) @(posedge clk_25);
    #1;
    check_eq("rst_ready", 32'(cmd_ready), 0);
    check_eq("rst_lines", 32'({scl_oe, sda_oe}), 0);
    check_eq("rst_rsp", 32'({rsp_valid, rsp_nack, rsp_rdata}), 0);
    @(negedge clk_25);
    reset = 0;
    @(posedge clk_25);
    #1;
    check_eq("ready_after_rst", 32'(cmd_ready), 1);

    run_cmd(1'b1, SLV_ADDR, 8'h03, 8'h00, 99);   // read returns 0x5A
    run_cmd(1'b0, SLV_ADDR, 8'h03, 8'hA5, 99);   // write E0,03,A5
    run_cmd(1'b1, SLV_ADDR, 8'h03, 8'h00, 99);   // read back 0xA5
    run_cmd(1'b0, 7'h11,    8'h03, 8'h3C, 99);   // address NACK
    run_cmd(1'b0, SLV_ADDR, 8'h10, 8'h77, 2);    // data byte NACK
    run_cmd(1'b0, SLV_ADDR, 8'h11, 8'h66, 1);    // register byte NACK
    run_cmd(1'b1, 7'h11,    8'h05, 8'h00, 99);   // read, address NACK
    run_cmd(1'b0, SLV_ADDR, 8'h10, 8'h99, 99);
    run_cmd(1'b1, SLV_ADDR, 8'h10, 8'h00, 99);

    for (int t = 0; t < 18; t++) begin
      k = $urandom_range(0, 3);
      nk = (k == 1) ? 1 : (k == 2) ? 2 : 99;
      run_cmd(1'($urandom), ($urandom_range(0, 2) != 0) ? SLV_ADDR : 7'($urandom),
              8'($urandom_range(0, 7)), 8'($urandom), nk);
    end

    // Reset in the middle of a read.
    @(negedge clk_25);
    nack_at = 99;
    cmd_rw = 1; cmd_dev_addr = SLV_ADDR; cmd_reg_addr = 8'h02; cmd_valid = 1;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk_25);
      w++;
    end
    check_eq("mid_accept", 32'(cmd_ready), 1);
    @(posedge clk_25);
    @(negedge clk_25);
    cmd_valid = 0;
    pulses = 0;
    k = $urandom_range(100, 400);
    for (int i = 0; i < k; i++) begin
      @(negedge clk_25);
      if (rsp_valid) pulses++;
    end
    reset = 1;
    @(posedge clk_25);
    #1;
    check_eq("mid_rst_lines", 32'({scl_oe, sda_oe}), 0);
    check_eq("mid_rst_ready", 32'(cmd_ready), 0);
    @(negedge clk_25);
    reset = 0;
    slv_reset = 1;
    @(posedge clk_25);
    #1;
    check_eq("mid_ready_after", 32'(cmd_ready), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25);
      if (rsp_valid) pulses++;
    end
    check_eq("mid_no_rsp", pulses, 0);

    run_cmd(1'b0, SLV_ADDR, 8'h04, 8'hC3, 99);
    run_cmd(1'b1, SLV_ADDR, 8'h04, 8'h00, 99);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
